// File: rtl/wshb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave, one owner per bus cycle.
// Define WSHB_ARB_TIMEOUT_EN to add a watchdog that errors the owner when the slave stalls.
module wshb_arbiter #(
    parameter int unsigned NUM_M   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [32*NUM_M-1:0]   m_adr_i,
    input  logic [8*NUM_M-1:0]    m_sel_i,
    input  logic [64*NUM_M-1:0]   m_dat_i,
    output logic [63:0]           m_dat_o,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic [NUM_M-1:0]      m_rty_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [31:0]           s_adr_o,
    output logic [7:0]            s_sel_o,
    output logic [63:0]           s_dat_o,
    input  logic [63:0]           s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [NUM_M-1:0]      gnt_o
);

    typedef enum logic {StIdle, StOwned} state_e;

    state_e           state_q;
    logic [NUM_M-1:0] gnt_q;
    logic [NUM_M-1:0] lgp_q;
    logic [NUM_M-1:0] pick;
    logic             stb_sel;
    logic             timeout;

    // Smallest cyclic distance after lgp wins, so scan distances from far to near.
    always_comb begin
        pick = '0;
        for (int p = 0; p < NUM_M; p++) begin
            if (lgp_q[p]) begin
                for (int k = NUM_M; k >= 1; k--) begin
                    if (m_cyc_i[(p + k) % NUM_M]) begin
                        pick = '0;
                        pick[(p + k) % NUM_M] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            lgp_q   <= {1'b1, {(NUM_M-1){1'b0}}};
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|m_cyc_i) begin
                        state_q <= StOwned;
                        gnt_q   <= pick;
                        lgp_q   <= pick;
                    end
                end
                StOwned: begin
                    if (!(|(m_cyc_i & gnt_q))) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    // AND-OR mux on the one-hot grant; an empty grant yields all zeros.
    always_comb begin
        stb_sel = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_q[i]) begin
                stb_sel = stb_sel | m_stb_i[i];
                s_we_o  = s_we_o | m_we_i[i];
                s_adr_o = s_adr_o | m_adr_i[32*i +: 32];
                s_sel_o = s_sel_o | m_sel_i[8*i +: 8];
                s_dat_o = s_dat_o | m_dat_i[64*i +: 64];
            end
        end
    end

`ifdef WSHB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;

    assign timeout = (state_q == StOwned) && (cnt_q == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q != StOwned || timeout || !stb_sel ||
                     s_ack_i || s_err_i || s_rty_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign s_cyc_o = (state_q == StOwned);
    assign s_stb_o = stb_sel & ~timeout;
    assign gnt_o   = gnt_q;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = gnt_q & {NUM_M{s_ack_i}};
    assign m_err_o = gnt_q & {NUM_M{s_err_i | timeout}};
    assign m_rty_o = gnt_q & {NUM_M{s_rty_i}};

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: directed scenarios plus random traffic against
// an owner/last-grant reference model.
module tb_wshb_arbiter;

    localparam int NM = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [31:0]      adr  [NM];
    logic [7:0]       sel  [NM];
    logic [63:0]      wdat [NM];
    logic [32*NM-1:0] m_adr;
    logic [8*NM-1:0]  m_sel;
    logic [64*NM-1:0] m_wdat;
    logic [63:0]      m_dat;
    logic [NM-1:0]    m_ack, m_err, m_rty, gnt;
    logic             s_cyc, s_stb, s_we;
    logic [31:0]      s_adr;
    logic [7:0]       s_sel;
    logic [63:0]      s_wdat, s_rdat;
    logic             s_ack, s_err, s_rty;

    for (genvar i = 0; i < NM; i++) begin : g_pack
        assign m_adr[32*i +: 32]  = adr[i];
        assign m_sel[8*i +: 8]    = sel[i];
        assign m_wdat[64*i +: 64] = wdat[i];
    end

    wshb_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_wdat),
        .m_dat_o (m_dat),
        .m_ack_o (m_ack),
        .m_err_o (m_err),
        .m_rty_o (m_rty),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_sel_o (s_sel),
        .s_dat_o (s_wdat),
        .s_dat_i (s_rdat),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .s_rty_i (s_rty),
        .gnt_o   (gnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 = idle), last granted index, stalled-cycle count.
    int   owner = -1;
    int   last  = NM - 1;
    int   stall = 0;
    logic tmo;

    logic [NM-1:0] order [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = NM - 1;
        stall = 0;
    endtask

    task automatic check_all();
        logic [NM-1:0] oh;
        oh = '0;
        if (owner >= 0) oh[owner] = 1'b1;
`ifdef WSHB_ARB_TIMEOUT_EN
        tmo = (owner >= 0) && (stall == TO);
`else
        tmo = 1'b0;
`endif
        chk("gnt", 64'(gnt), 64'(oh));
        chk("s_cyc", 64'(s_cyc), 64'(owner >= 0));
        if (owner >= 0) begin
            chk("s_stb", 64'(s_stb), 64'(m_stb[owner] && !tmo));
            chk("s_we", 64'(s_we), 64'(m_we[owner]));
            chk("s_adr", 64'(s_adr), 64'(adr[owner]));
            chk("s_sel", 64'(s_sel), 64'(sel[owner]));
            chk("s_dat", s_wdat, wdat[owner]);
        end else begin
            chk("s_stb_idle", 64'(s_stb), 64'(0));
            chk("s_we_idle", 64'(s_we), 64'(0));
            chk("s_adr_idle", 64'(s_adr), 64'(0));
            chk("s_sel_idle", 64'(s_sel), 64'(0));
            chk("s_dat_idle", s_wdat, 64'(0));
        end
        chk("m_ack", 64'(m_ack), s_ack ? 64'(oh) : 64'(0));
        chk("m_err", 64'(m_err), (s_err || tmo) ? 64'(oh) : 64'(0));
        chk("m_rty", 64'(m_rty), s_rty ? 64'(oh) : 64'(0));
        chk("m_dat", m_dat, s_rdat);
    endtask

    task automatic model_edge();
        if (owner < 0) begin
            stall = 0;
            for (int k = 1; k <= NM; k++) begin
                int j;
                j = (last + k) % NM;
                if (m_cyc[j]) begin
                    owner = j;
                    last  = j;
                    break;
                end
            end
        end else begin
            if (tmo || !m_stb[owner] || s_ack || s_err || s_rty) stall = 0;
            else stall++;
            if (!m_cyc[owner]) owner = -1;
        end
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, advances model at the edge.
    task automatic cycle();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int i = 0; i < NM; i++) begin
            adr[i]  = 32'h1000 * (i + 1);
            sel[i]  = 8'(8'h11 * (i + 1));
            wdat[i] = {32'hABCD0000 + i, 32'h00001234 + i};
        end
        s_rdat = 64'h0123_4567_89AB_CDEF;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    initial begin
        logic e_arr [12];
        logic st_arr [12];
        int   first;
        int   pulses;

        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Masters 0,1,3 together from reset; each drops after one acked transfer.
        m_cyc = 4'b1011;
        m_stb = 4'b1011;
        for (int c = 0; c < 30 && m_cyc != '0; c++) begin
            int o;
            o = owner;
            s_ack = (o >= 0) && m_cyc[o];
            cycle();
            if (gnt != '0 && (order.size() == 0 || order[order.size()-1] != gnt))
                order.push_back(gnt);
            if (o >= 0 && s_ack) begin
                m_cyc[o] = 1'b0;
                m_stb[o] = 1'b0;
            end
        end
        s_ack = 1'b0;
        cycle();
        chk("order_len", 64'(order.size()), 64'(3));
        chk("order_0", 64'(order[0]), 64'(4'b0001));
        chk("order_1", 64'(order[1]), 64'(4'b0010));
        chk("order_2", 64'(order[2]), 64'(4'b1000));

        // Wrap-around: after master 3, masters 3 and 0 request together.
        m_cyc = 4'b1001;
        cycle();
        chk("wrap_gnt", 64'(gnt), 64'(4'b0001));
        m_cyc = '0;
        cycle();
        cycle();

        // Master 2 alone, write to 0x100.
        m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
        adr[2] = 32'h100; sel[2] = 8'hFF;
        cycle();
        chk("m2_gnt", 64'(gnt), 64'(4'b0100));
        s_ack = 1'b1;
        #2;
        chk("m2_adr", 64'(s_adr), 64'h100);
        chk("m2_we", 64'(s_we), 64'(1));
        chk("m2_ack", 64'(m_ack), 64'(4'b0100));
        #(-0) cycle();
        s_ack = 1'b0;
        clear_inputs();
        cycle();
        cycle();

        // Reset mid-transfer while master 1 owns the bus.
        m_cyc = 4'b0010; m_stb = 4'b0010;
        cycle();
        chk("m1_gnt", 64'(gnt), 64'(4'b0010));
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_s_cyc", 64'(s_cyc), 64'(0));
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_m_ack", 64'(m_ack), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        s_ack = 1'b0;
        check_all();
        rst_n = 1'b1;
        m_cyc = 4'b0011; m_stb = 4'b0011;
        cycle();
        chk("post_rst_gnt", 64'(gnt), 64'(4'b0001));
        clear_inputs();
        cycle();
        cycle();

        // Stalled slave: master 0 holds stb, slave never terminates.
        m_cyc = 4'b0001; m_stb = 4'b0001;
        cycle();
        for (int k = 0; k < 12; k++) begin
            #2;
            e_arr[k]  = m_err[0];
            st_arr[k] = s_stb;
            #(-0) cycle();
        end
        first = -1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (e_arr[k]) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
`ifdef WSHB_ARB_TIMEOUT_EN
        chk("tmo_first", 64'(first), 64'(4));
        chk("tmo_pulses", 64'(pulses), 64'(2));
        chk("tmo_stb_low", 64'(st_arr[4]), 64'(0));
        chk("tmo_stb_before", 64'(st_arr[3]), 64'(1));
`else
        chk("no_tmo_first", 64'(first), 64'(-1));
        chk("no_tmo_pulses", 64'(pulses), 64'(0));
        chk("no_tmo_stb", 64'(st_arr[11]), 64'(1));
`endif
        clear_inputs();
        cycle();
        cycle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            int t;
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(3) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    m_cyc[i] = 1'b1;
                end
                m_stb[i] = ($urandom_range(3) != 0);
                m_we[i]  = 1'($urandom);
                adr[i]   = $urandom;
                sel[i]   = 8'($urandom);
                wdat[i]  = {$urandom, $urandom};
            end
            s_rdat = {$urandom, $urandom};
            t = int'($urandom_range(5));
            s_ack = (t == 0);
            s_err = (t == 1);
            s_rty = (t == 2);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 Parameter NUM_M, default 4: number of Wishbone masters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255: watchdog limit in clock cycles; legal range 1..65535; used only when WSHB_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m_cyc_i  input  NUM_M  per-master cycle request; bit i belongs to master i.
REQ-006 m_stb_i, m_we_i  input  NUM_M each  per-master strobe and write enable.
REQ-007 m_adr_i  input  32*NUM_M  per-master address; slice [32i+31:32i] belongs to master i.
REQ-008 m_sel_i  input  8*NUM_M  per-master byte selects.
REQ-009 m_dat_i  input  64*NUM_M  per-master write data.
REQ-010 m_dat_o  output  64  read data, driven from s_dat_i to all masters.
REQ-011 m_ack_o, m_err_o, m_rty_o  output  NUM_M each  per-master termination signals.
REQ-012 s_cyc_o, s_stb_o, s_we_o  output  1 each  shared-slave control.
REQ-013 s_adr_o  output  32;  s_sel_o  output  8;  s_dat_o  output  64  shared-slave address, byte selects and write data.
REQ-014 s_dat_i  input  64;  s_ack_i, s_err_i, s_rty_i  input  1 each  shared-slave read data and terminations.
REQ-015 gnt_o  output  NUM_M  one-hot current grant; all zero when idle.

Function
REQ-016 The FSM SHALL have two states, IDLE and OWNED, plus an NUM_M-wide last-grant pointer (lgp).
REQ-017 In IDLE, if any m_cyc_i bit is set, the block SHALL register a grant to the first requesting index strictly after lgp, searching cyclically and wrapping past NUM_M-1 to 0, then enter OWNED and update lgp.
REQ-018 Grant latency SHALL be exactly one clock: s_cyc_o rises in the cycle after m_cyc_i is first sampled high in IDLE.
REQ-019 In OWNED, s_cyc_o SHALL be 1, and s_stb_o, s_we_o, s_adr_o, s_sel_o and s_dat_o SHALL be combinational copies of the granted master's signals.
REQ-020 s_ack_i, s_err_i and s_rty_i SHALL be routed combinationally to the granted master's bit only; all other masters' terminations SHALL be 0.
REQ-021 In OWNED, a sampled low on the granted master's m_cyc_i SHALL return the FSM to IDLE; s_cyc_o and gnt_o are 0 for at least one cycle before any regrant.
REQ-022 Request changes from non-granted masters SHALL have no effect in OWNED; there is no preemption.
REQ-023 In IDLE, all s_* outputs, gnt_o and all m_ack_o, m_err_o and m_rty_o bits SHALL be 0.
REQ-024 A slave termination that arrives in IDLE SHALL be dropped.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously force IDLE, gnt_o=0 and all s_* and termination outputs to 0, at any point including mid-transfer.
REQ-026 Reset SHALL set lgp to NUM_M-1, so master 0 has first priority after reset.
REQ-027 After rst_n deasserts, the first grant SHALL occur no earlier than the first posedge with rst_n high.

Configuration
REQ-028 Macro WSHB_ARB_TIMEOUT_EN defined: a counter SHALL count OWNED cycles in which s_stb_o=1 and no slave termination is present.
REQ-029 With the macro defined, the counter SHALL clear on any termination or on s_stb_o=0.
REQ-030 With the macro defined, when the counter reaches TIMEOUT, the block SHALL assert m_err_o for the granted master for exactly one cycle, force s_stb_o=0 in that cycle, and clear the counter.
REQ-031 Macro WSHB_ARB_TIMEOUT_EN undefined: the counter and forced error SHALL NOT exist, and a stalled slave holds the bus indefinitely.

Verification
REQ-032 Master 2 alone raises cyc+stb with a write to address 0x100 and sel 0xFF -> gnt_o=0100 one cycle later; slave sees adr 0x100 and we=1; slave ack is seen only on m_ack_o[2].
REQ-033 Masters 0,1,3 request together from reset, and each drops cyc after one transfer -> grant order 0,1,3, with one idle cycle between grants.
REQ-034 After master 3 is served, masters 3 and 0 request together -> master 0 is granted (wrap-around).
REQ-035 Master 1 is owning when rst_n is pulled low mid-stb -> s_cyc_o, gnt_o and m_ack_o are 0 immediately; the next grant after release goes to master 0.
REQ-036 Macro defined, TIMEOUT=4, and the slave never terminates -> m_err_o of the owner pulses for exactly 1 cycle after 4 stalled cycles, with s_stb_o low in that cycle; the same stimulus with the macro undefined produces no error.
